// File: rtl/i2c_apb_regfile_fifo.sv
// APB register block for the I2C core: PRESCALER/CMD/ADDRESS_RW registers plus TX/RX data FIFOs.
// Latency: one SETUP cycle, then WAIT_STATES PREADY-low cycles, then one PREADY-high cycle where side effects commit.
// Backpressure: a full TX FIFO or empty RX FIFO rejects the APB access with PSLVERR; the core must honour the flags.
// Optional feature: define I2C_REGFILE_IRQ_EN to add IRQ_o and the IRQ_EN register at 0x07.

// Small show-ahead FIFO: push while full and pop while empty are dropped.
module i2c_regfile_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; contents are only observed when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module i2c_apb_regfile_fifo #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK_i,
    input  logic              PRESET_i,
    input  logic              PSEL_i,
    input  logic              PENABLE_i,
    input  logic              PWRITE_i,
    input  logic [ADDR_W-1:0] PADDR_i,
    input  logic [DATA_W-1:0] PWDATA_i,
    output logic [DATA_W-1:0] PRDATA_o,
    output logic              PREADY_o,
    output logic              PSLVERR_o,
    input  logic [DATA_W-1:0] STATUS_i,
    output logic [DATA_W-1:0] PRESCALER_o,
    output logic [DATA_W-1:0] CMD_o,
    output logic [DATA_W-1:0] ADDRESS_RW_o,
    output logic [DATA_W-1:0] TX_DATA_o,
    output logic              TX_EMPTY_o,
    input  logic              TX_RD_i,
    input  logic [DATA_W-1:0] RX_DATA_i,
    input  logic              RX_WR_i,
`ifdef I2C_REGFILE_IRQ_EN
    output logic              IRQ_o,
`endif
    output logic              RX_FULL_o
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TX     = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RX     = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_ADDRRW = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_FSTAT  = ADDR_W'(6);
`ifdef I2C_REGFILE_IRQ_EN
    localparam logic [ADDR_W-1:0] A_IRQEN  = ADDR_W'(7);
    logic [DATA_W-1:0] irq_en;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              err_q;
    logic [DATA_W-1:0] rdat_q;

    logic              access_err;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] setup_rdat;
    logic              commit;

    logic              tx_full;
    logic              rx_empty;
    logic [DATA_W-1:0] rx_head;

    // Commit only in the PREADY cycle of a still-selected, error-free transfer.
    assign commit     = (state == ACCESS) && PREADY_o && PSEL_i && !PSLVERR_o;
    assign setup_rdat = (access_err || PWRITE_i) ? '0 : rd_mux;

    i2c_regfile_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (PCLK_i),
        .rst      (PRESET_i),
        .push     (commit && PWRITE_i && (PADDR_i == A_TX)),
        .push_dat (PWDATA_i),
        .pop      (TX_RD_i),
        .head     (TX_DATA_o),
        .empty    (TX_EMPTY_o),
        .full     (tx_full)
    );

    i2c_regfile_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (PCLK_i),
        .rst      (PRESET_i),
        .push     (RX_WR_i),
        .push_dat (RX_DATA_i),
        .pop      (commit && !PWRITE_i && (PADDR_i == A_RX)),
        .head     (rx_head),
        .empty    (rx_empty),
        .full     (RX_FULL_o)
    );

    // Decode the access: error classification and read data, sampled in SETUP.
    // TX can only fill and RX only drain through APB, so the verdict stays valid until commit.
    always_comb begin
        access_err = 1'b0;
        rd_mux     = '0;
        if (PWRITE_i) begin
            case (PADDR_i)
                A_PRESC, A_CMD, A_ADDRRW: access_err = 1'b0;
                A_TX:                     access_err = tx_full;
`ifdef I2C_REGFILE_IRQ_EN
                A_IRQEN:                  access_err = 1'b0;
`endif
                default:                  access_err = 1'b1;
            endcase
        end else begin
            case (PADDR_i)
                A_PRESC:  rd_mux = PRESCALER_o;
                A_CMD:    rd_mux = CMD_o;
                A_RX: begin
                    rd_mux     = rx_head;
                    access_err = rx_empty;
                end
                A_ADDRRW: rd_mux = ADDRESS_RW_o;
                A_STATUS: rd_mux = STATUS_i;
                A_FSTAT:  rd_mux[3:0] = {RX_FULL_o, rx_empty, tx_full, TX_EMPTY_o};
`ifdef I2C_REGFILE_IRQ_EN
                A_IRQEN:  rd_mux = irq_en;
`endif
                default:  access_err = 1'b1;
            endcase
        end
    end

    // APB handshake FSM with registered PREADY/PSLVERR/PRDATA.
    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
            PREADY_o  <= 1'b0;
            PSLVERR_o <= 1'b0;
            PRDATA_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    PREADY_o  <= 1'b0;
                    PSLVERR_o <= 1'b0;
                    PRDATA_o  <= '0;
                    if (PSEL_i && !PENABLE_i) state <= SETUP;
                end
                SETUP: begin
                    if (!PSEL_i) begin
                        state <= IDLE;
                    end else begin
                        state    <= ACCESS;
                        wait_cnt <= WS;
                        err_q    <= access_err;
                        rdat_q   <= setup_rdat;
                        if (WS == 4'd0) begin
                            PREADY_o  <= 1'b1;
                            PSLVERR_o <= access_err;
                            PRDATA_o  <= setup_rdat;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSEL_i || PREADY_o) begin
                        state     <= IDLE;
                        PREADY_o  <= 1'b0;
                        PSLVERR_o <= 1'b0;
                        PRDATA_o  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            PREADY_o  <= 1'b1;
                            PSLVERR_o <= err_q;
                            PRDATA_o  <= rdat_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Software-writable control registers.
    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            PRESCALER_o  <= '0;
            CMD_o        <= '0;
            ADDRESS_RW_o <= '0;
`ifdef I2C_REGFILE_IRQ_EN
            irq_en       <= '0;
`endif
        end else if (commit && PWRITE_i) begin
            case (PADDR_i)
                A_PRESC:  PRESCALER_o  <= PWDATA_i;
                A_CMD:    CMD_o        <= PWDATA_i;
                A_ADDRRW: ADDRESS_RW_o <= PWDATA_i;
`ifdef I2C_REGFILE_IRQ_EN
                A_IRQEN:  irq_en       <= PWDATA_i;
`endif
                default: ;
            endcase
        end
    end

`ifdef I2C_REGFILE_IRQ_EN
    // Interrupt is registered, so it follows its condition by one cycle.
    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) IRQ_o <= 1'b0;
        else          IRQ_o <= |(irq_en[2:0] & {!rx_empty, RX_FULL_o, TX_EMPTY_o});
    end
`endif
endmodule
